// File: rtl/message_bus_pkg.sv
// Shared width defaults and index-width helper for the message-bus arbiter slice.
package message_bus_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ID_WIDTH   = 9;

    // Index/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_index_fifo.sv
// In-order FIFO of granted master indices; the head names the master owed the next response.
module rr_index_fifo
    import message_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    localparam int PTR_W = clog2_min1(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];

    // Next-state for storage, wrapping pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = push ? ((wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? ((rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/message_bus_arb.sv
// Round-robin N-to-1 message-bus arbiter with in-order response routing back to the issuer.
module message_bus_arb
    import message_bus_pkg::*;
#(
    parameter int NB_MASTERS      = 8,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ID_WIDTH        = DEFAULT_ID_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W    = clog2_min1(NB_MASTERS),
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_MASTERS-1:0]          mst_req_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] mst_add_i,
    input  logic [NB_MASTERS-1:0]          mst_wen_i,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0] mst_wdata_i,
    input  logic [NB_MASTERS*BE_WIDTH-1:0] mst_be_i,
    input  logic [NB_MASTERS*ID_WIDTH-1:0] mst_id_i,
    output logic [NB_MASTERS-1:0]          mst_gnt_o,
    output logic [NB_MASTERS-1:0]          mst_r_valid_o,
    output logic                           mst_r_opc_o,
    output logic [ID_WIDTH-1:0]            mst_r_id_o,
    output logic [DATA_WIDTH-1:0]          mst_r_rdata_o,
    output logic                           slv_req_o,
    output logic [ADDR_WIDTH-1:0]          slv_add_o,
    output logic                           slv_wen_o,
    output logic [DATA_WIDTH-1:0]          slv_wdata_o,
    output logic [BE_WIDTH-1:0]            slv_be_o,
    output logic [ID_WIDTH-1:0]            slv_id_o,
    input  logic                           slv_gnt_i,
    input  logic                           slv_r_valid_i,
    input  logic                           slv_r_opc_i,
    input  logic [ID_WIDTH-1:0]            slv_r_id_i,
    input  logic [DATA_WIDTH-1:0]          slv_r_rdata_i,
    output logic [CNT_W-1:0]               outstanding_o,
    output logic                           err_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] winner_s, head_s, cand_s;
    logic [IDX_W:0]   cand_sum_s;
    logic             found_s, fifo_full_s, fifo_empty_s, hs_s, pop_s, sel_s;

    // Scan from rr_ptr upward (wrapping) and keep the first requester.
    always_comb begin
        winner_s   = '0;
        found_s    = 1'b0;
        cand_sum_s = '0;
        cand_s     = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            cand_sum_s = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
            cand_s     = (cand_sum_s >= (IDX_W + 1)'(NB_MASTERS)) ?
                         IDX_W'(cand_sum_s - (IDX_W + 1)'(NB_MASTERS)) : IDX_W'(cand_sum_s);
            winner_s   = (mst_req_i[cand_s] && !found_s) ? cand_s : winner_s;
            found_s    = found_s | mst_req_i[cand_s];
        end
    end

    // AND-OR mux of the winner's request fields; all zero when nobody requests.
    always_comb begin
        slv_add_o   = '0;
        slv_wen_o   = 1'b0;
        slv_wdata_o = '0;
        slv_be_o    = '0;
        slv_id_o    = '0;
        sel_s       = 1'b0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            sel_s       = found_s && (winner_s == IDX_W'(i));
            slv_add_o   = slv_add_o   | ({ADDR_WIDTH{sel_s}} & mst_add_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
            slv_wen_o   = slv_wen_o   | (sel_s & mst_wen_i[i]);
            slv_wdata_o = slv_wdata_o | ({DATA_WIDTH{sel_s}} & mst_wdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
            slv_be_o    = slv_be_o    | ({BE_WIDTH{sel_s}} & mst_be_i[i*BE_WIDTH +: BE_WIDTH]);
            slv_id_o    = slv_id_o    | ({ID_WIDTH{sel_s}} & mst_id_i[i*ID_WIDTH +: ID_WIDTH]);
        end
    end

    // Full blocks requests regardless of a same-cycle pop, keeping r_valid off the req path.
    assign slv_req_o     = (|mst_req_i) && !fifo_full_s;
    assign hs_s          = slv_req_o && slv_gnt_i;
    assign pop_s         = slv_r_valid_i && !fifo_empty_s;
    assign mst_gnt_o     = hs_s  ? (NB_MASTERS'(1) << winner_s) : '0;
    assign mst_r_valid_o = pop_s ? (NB_MASTERS'(1) << head_s)   : '0;
    assign mst_r_opc_o   = slv_r_valid_i & slv_r_opc_i;
    assign mst_r_id_o    = slv_r_valid_i ? slv_r_id_i    : '0;
    assign mst_r_rdata_o = slv_r_valid_i ? slv_r_rdata_i : '0;
    assign err_o         = err_q;

    // Pointer advances past the winner only on a handshake; unmatched responses latch an error.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs_s) begin
            rr_ptr_d = (winner_s == IDX_W'(NB_MASTERS - 1)) ? '0 : winner_s + 1'b1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        err_d = err_q | (slv_r_valid_i & fifo_empty_s);
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    rr_index_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_idx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (hs_s),
        .pop      (pop_s),
        .data_in  (winner_s),
        .data_out (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (outstanding_o)
    );

endmodule

// File: doc/message_bus_arb.md
Name: message_bus_arb

Overview:
- Parametrised N-to-1 successor of the event-unit message bus.
- Arbitrates NB_MASTERS message-bus masters onto one slave port using round-robin.
- Forwards request fields from the winning master.
- Tracks in-order outstanding transactions in a small index FIFO, so each slave response (r_valid/r_opc/r_id/r_rdata) returns to the master that issued it.
- Sits between the cores' message-bus ports and a shared event-unit/peripheral slave.

Parameters:
- NB_MASTERS, 8: number of master ports (>=2).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: wdata/r_rdata width; BE_WIDTH = DATA_WIDTH/8.
- ID_WIDTH, 9: request/response id width; passed through unchanged.
- MAX_OUTSTANDING, 4: index-FIFO depth (>=1); maximum in-flight requests.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mst_req_i  in  NB_MASTERS  per-master request.
- mst_add_i  in  NB_MASTERS x ADDR_WIDTH  per-master address.
- mst_wen_i  in  NB_MASTERS  per-master write-enable (1 = read, codebase convention).
- mst_wdata_i  in  NB_MASTERS x DATA_WIDTH  write data.
- mst_be_i  in  NB_MASTERS x BE_WIDTH  byte enables.
- mst_id_i  in  NB_MASTERS x ID_WIDTH  request id.
- mst_gnt_o  out  NB_MASTERS  per-master grant.
- mst_r_valid_o  out  NB_MASTERS  per-master response valid.
- mst_r_opc_o  out  1  response opcode/error (broadcast).
- mst_r_id_o  out  ID_WIDTH  response id (broadcast).
- mst_r_rdata_o  out  DATA_WIDTH  response data (broadcast).
- slv_req_o, slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_id_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/BE_WIDTH/ID_WIDTH  forwarded request.
- slv_gnt_i  in  1  slave grant.
- slv_r_valid_i, slv_r_opc_i, slv_r_id_i, slv_r_rdata_i  in  1/1/ID_WIDTH/DATA_WIDTH  slave response.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: rr_ptr = 0, FIFO empty, outstanding_o = 0, err_o = 0. All request/grant/response outputs are combinational and read 0 while no master requests and no slave response is present.
- Arbitration is combinational:
  - Winner = first index w with mst_req_i[w]=1, scanning rr_ptr, rr_ptr+1, ... modulo NB_MASTERS.
  - slv_req_o = |mst_req_i && !fifo_full.
  - slv_* fields = winner's fields; all zero when no winner.
- Grant: mst_gnt_o[w] = slv_gnt_i && slv_req_o && (w == winner); all other bits 0. Zero-latency pass-through.
- Handshake (slv_req_o && slv_gnt_i):
  - Push winner index into the FIFO.
  - rr_ptr <= (winner+1) mod NB_MASTERS.
  - rr_ptr is unchanged in cycles without a handshake.
- Masters hold their request until granted. The winner may change before the grant if a higher-priority master raises req; this is legal because no transaction exists until gnt.
- Response (slv_r_valid_i=1, FIFO non-empty):
  - mst_r_valid_o[head] = 1 in the same cycle.
  - r_opc/r_id/r_rdata forwarded unchanged.
  - Pop head at the clock edge.
- Responses are strictly in-order; the slave guarantees ordering, and r_id is not used for routing.
- slv_r_valid_i with FIFO empty: no mst_r_valid_o asserted, err_o <= 1 (sticky until reset).
- FIFO full (count == MAX_OUTSTANDING): slv_req_o = 0 and all gnt = 0, even if a pop occurs in the same cycle. This keeps the path from r_valid to req out of the logic.
- Push and pop in the same cycle (not full): count unchanged; FIFO read/write pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o = FIFO count, registered.
- Reset mid-operation: FIFO flushed and rr_ptr = 0. Any responses arriving after reset for pre-reset requests are treated as errors (err_o).

Decomposition:
- Package message_bus_pkg holds:
  - the default width constants (ADDR_WIDTH, DATA_WIDTH, ID_WIDTH);
  - a function returning clog2 with a minimum of 1.
- Sub-module rr_index_fifo:
  - parametrised DEPTH and WIDTH = $clog2(NB_MASTERS);
  - ports push/pop/data_in/data_out/full/empty/count;
  - asynchronous active-low reset.
- Round-robin winner selection stays inline.

Test Plan:
- Single master 3 requests with slv_gnt_i=1 (add=0x10, 0x14, 0x18, id=0x05), responses returned in order: mst_gnt_o[3] asserted in 3 consecutive cycles; mst_r_valid_o[3] asserted 3 times with rdata 0xA0, 0xA1, 0xA2; outstanding_o goes 1, 2, 3 then back to 0.
- Masters 0, 2 and 5 hold req continuously with slv_gnt_i=1 and immediate responses: grant order is 0, 2, 5, 0, 2, 5; rr_ptr after the first grant is 1.
- MAX_OUTSTANDING=4, slave never responds, master 1 requests 6 times: exactly 4 grants; slv_req_o=0 from then on; outstanding_o=4. One response then allows exactly one more grant on the following cycle.
- slv_r_valid_i=1 with FIFO empty: all mst_r_valid_o=0; err_o=1 next cycle and remains 1 through further traffic until rst_ni=0.
- Issue master 7 then master 0, respond with r_opc=1 and r_id=0x1FF: mst_r_valid_o[7] asserted first, then mst_r_valid_o[0]; mst_r_id_o=0x1FF and mst_r_opc_o=1 on both responses.
- Assert rst_ni=0 with 2 outstanding: outstanding_o=0, rr_ptr=0, err_o=0 immediately; after release, master 4 alone is granted on its first request.
